// File: rtl/bus_target_memory.sv
// Bus target backed by a single-port 32-bit RAM window: byte-masked write bursts,
// streamed read bursts with initiator back-pressure, and rejection of misaligned begins.
module bus_target_memory #(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int unsigned ADDR_BITS    = 8
) (
  input  logic        clock,
  input  logic        n_reset,
  input  logic [31:0] address_dataIN,
  input  logic [3:0]  byte_enableIN,
  input  logic [7:0]  burst_sizeIN,
  input  logic        read_n_writeIN,
  input  logic        begin_transactionIN,
  input  logic        end_transactionIN,
  input  logic        data_validIN,
  input  logic        busyIN,
  output logic [31:0] address_dataOUT,
  output logic        end_transactionOUT,
  output logic        data_validOUT,
  output logic        busyOUT,
  output logic        errorOUT
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] IdxOne = ADDR_BITS'(1);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StReadFetch,
    StReadData,
    StReadEnd,
    StError
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] index_q, index_d;
  logic [8:0]           count_q, count_d;
  logic [31:0]          mem [Depth];
  logic [31:0]          rdata_q;
  logic                 mem_we;
  logic                 mem_re;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 selected;

  assign selected = address_dataIN[31:ADDR_BITS+2] == BASE_ADDRESS[31:ADDR_BITS+2];
  assign busyOUT  = 1'b0;

  always_comb begin
    state_d            = state_q;
    index_d            = index_q;
    count_d            = count_q;
    mem_we             = 1'b0;
    mem_re             = 1'b0;
    rd_addr            = index_q;
    data_validOUT      = 1'b0;
    end_transactionOUT = 1'b0;
    errorOUT           = 1'b0;
    address_dataOUT    = '0;
    unique case (state_q)
      StIdle: begin
        if (begin_transactionIN && selected) begin
          if (address_dataIN[1:0] != 2'b00) begin
            state_d = StError;
          end else begin
            index_d = address_dataIN[ADDR_BITS+1:2];
            count_d = {1'b0, burst_sizeIN} + 9'd1;
            state_d = read_n_writeIN ? StReadFetch : StWrite;
          end
        end
      end
      StWrite: begin
        if (data_validIN && (count_q != 9'd0)) begin
          mem_we  = 1'b1;
          index_d = index_q + IdxOne;
          count_d = count_q - 9'd1;
        end
        if (end_transactionIN) state_d = StIdle;
      end
      StReadFetch: begin
        mem_re  = 1'b1;
        state_d = end_transactionIN ? StIdle : StReadData;
      end
      StReadData: begin
        data_validOUT   = 1'b1;
        address_dataOUT = rdata_q;
        mem_re          = 1'b1;
        if (end_transactionIN) begin
          state_d = StIdle;
        end else if (!busyIN) begin
          // Prefetch the following word now so the stream has no bubbles.
          rd_addr = index_q + IdxOne;
          index_d = index_q + IdxOne;
          count_d = count_q - 9'd1;
          if (count_q == 9'd1) state_d = StReadEnd;
        end
      end
      StReadEnd: begin
        end_transactionOUT = 1'b1;
        state_d            = StIdle;
      end
      StError: begin
        errorOUT = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= StIdle;
      index_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      count_q <= count_d;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_enableIN[i]) mem[index_q][8*i +: 8] <= address_dataIN[8*i +: 8];
      end
    end
    if (mem_re) rdata_q <= mem[rd_addr];
  end

endmodule

// File: tb/tb_bus_target_memory.sv
// Directed bench for bus_target_memory; read words are checked against a queue of
// expected values filled when each burst is issued.
module tb_bus_target_memory;

  logic        clock = 1'b0;
  logic        n_reset;
  logic [31:0] address_dataIN;
  logic [3:0]  byte_enableIN;
  logic [7:0]  burst_sizeIN;
  logic        read_n_writeIN;
  logic        begin_transactionIN;
  logic        end_transactionIN;
  logic        data_validIN;
  logic        busyIN;
  logic [31:0] address_dataOUT;
  logic        end_transactionOUT;
  logic        data_validOUT;
  logic        busyOUT;
  logic        errorOUT;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  bus_target_memory dut (
    .clock              (clock),
    .n_reset            (n_reset),
    .address_dataIN     (address_dataIN),
    .byte_enableIN      (byte_enableIN),
    .burst_sizeIN       (burst_sizeIN),
    .read_n_writeIN     (read_n_writeIN),
    .begin_transactionIN(begin_transactionIN),
    .end_transactionIN  (end_transactionIN),
    .data_validIN       (data_validIN),
    .busyIN             (busyIN),
    .address_dataOUT    (address_dataOUT),
    .end_transactionOUT (end_transactionOUT),
    .data_validOUT      (data_validOUT),
    .busyOUT            (busyOUT),
    .errorOUT           (errorOUT)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic start(input logic [31:0] addr, input logic [7:0] size, input logic rnw);
    address_dataIN      = addr;
    burst_sizeIN        = size;
    read_n_writeIN      = rnw;
    begin_transactionIN = 1'b1;
    cyc();
    begin_transactionIN = 1'b0;
    address_dataIN      = '0;
    burst_sizeIN        = '0;
    read_n_writeIN      = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] data, input logic [3:0] be);
    address_dataIN = data;
    byte_enableIN  = be;
    data_validIN   = 1'b1;
    cyc();
    data_validIN   = 1'b0;
    address_dataIN = '0;
    byte_enableIN  = '0;
  endtask

  task automatic write_end();
    end_transactionIN = 1'b1;
    cyc();
    end_transactionIN = 1'b0;
  endtask

  task automatic write_one(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
    start(addr, 8'd0, 1'b0);
    write_word(data, be);
    write_end();
  endtask

  // Issues a read burst and drains exp_q; stall_n busy cycles are applied on word stall_word.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] size,
                         input int stall_word, input int stall_n);
    int w    = 0;
    int held = 0;
    start(addr, size, 1'b1);
    chk_bit("fetch_valid", data_validOUT, 1'b0);
    cyc();
    chk_bit("first_valid_latency", data_validOUT, 1'b1);
    for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
      chk_bit("stream_valid", data_validOUT, 1'b1);
      chk("read_word", address_dataOUT, exp_q[0]);
      chk_bit("stream_end_low", end_transactionOUT, 1'b0);
      busyIN = (w == stall_word) && (held < stall_n);
      if (busyIN) held++;
      else begin
        void'(exp_q.pop_front());
        w++;
      end
      cyc();
    end
    busyIN = 1'b0;
    chk("read_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    chk("hold_cycles", 32'(held), 32'(stall_n));
    chk_bit("end_pulse", end_transactionOUT, 1'b1);
    chk_bit("end_valid_low", data_validOUT, 1'b0);
    chk("end_data_zero", address_dataOUT, 32'd0);
    cyc();
    chk_bit("end_single", end_transactionOUT, 1'b0);
  endtask

  initial begin
    address_dataIN      = '0;
    byte_enableIN       = '0;
    burst_sizeIN        = '0;
    read_n_writeIN      = 1'b0;
    begin_transactionIN = 1'b0;
    end_transactionIN   = 1'b0;
    data_validIN        = 1'b0;
    busyIN              = 1'b0;
    n_reset             = 1'b0;
    #3;
    chk("rst_data", address_dataOUT, 32'd0);
    chk_bit("rst_valid", data_validOUT, 1'b0);
    chk_bit("rst_end", end_transactionOUT, 1'b0);
    chk_bit("rst_error", errorOUT, 1'b0);
    chk_bit("rst_busy", busyOUT, 1'b0);
    cyc();
    @(negedge clock);
    n_reset = 1'b1;

    // Pre-fill a word just past the main burst to catch writes beyond the count.
    write_one(32'h5000_0020, 32'h0000_0055, 4'hF);

    start(32'h5000_0010, 8'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      write_word(32'hA0 + 32'(i), 4'hF);
      chk_bit("wr_error_low", errorOUT, 1'b0);
      chk_bit("wr_valid_low", data_validOUT, 1'b0);
    end
    write_word(32'hDEAD_BEEF, 4'hF);
    write_end();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + 32'(i));
    do_read(32'h5000_0010, 8'd3, -1, 0);
    exp_q.push_back(32'h0000_0055);
    do_read(32'h5000_0020, 8'd0, -1, 0);

    write_one(32'h5000_0000, 32'hFFFF_FFFF, 4'hF);
    write_one(32'h5000_0000, 32'h1234_5678, 4'b0101);
    exp_q.push_back(32'hFF34_FF78);
    do_read(32'h5000_0000, 8'd0, -1, 0);

    start(32'h5000_03FC, 8'd1, 1'b0);
    write_word(32'h11, 4'hF);
    chk_bit("wrap_error_low", errorOUT, 1'b0);
    write_word(32'h22, 4'hF);
    chk_bit("wrap_error_low", errorOUT, 1'b0);
    write_end();
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h22);
    do_read(32'h5000_03FC, 8'd1, -1, 0);
    exp_q.push_back(32'h22);
    do_read(32'h5000_0000, 8'd0, -1, 0);

    start(32'h5000_0040, 8'd2, 1'b0);
    for (int i = 0; i < 3; i++) write_word(32'h301 + 32'(i), 4'hF);
    write_end();
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h301 + 32'(i));
    do_read(32'h5000_0040, 8'd2, 1, 3);

    start(32'h6000_0000, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("miss_quiet", {address_dataOUT[31:3], data_validOUT, end_transactionOUT, errorOUT} |
          {29'd0, 3'b000} | {3'b000, address_dataOUT[2:0], 26'd0}, 32'd0);
      cyc();
    end
    start(32'h5000_0002, 8'd0, 1'b0);
    chk_bit("misaligned_error", errorOUT, 1'b1);
    write_word(32'hBAD0_BAD0, 4'hF);
    chk_bit("error_single", errorOUT, 1'b0);
    exp_q.push_back(32'h22);
    do_read(32'h5000_0000, 8'd0, -1, 0);

    start(32'h5000_0010, 8'd3, 1'b1);
    cyc();
    chk_bit("pre_reset_valid", data_validOUT, 1'b1);
    busyIN = 1'b1;
    #2;
    n_reset = 1'b0;
    #1;
    chk_bit("async_rst_valid", data_validOUT, 1'b0);
    chk("async_rst_data", address_dataOUT, 32'd0);
    busyIN = 1'b0;
    cyc();
    cyc();
    @(negedge clock);
    n_reset = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + 32'(i));
    do_read(32'h5000_0010, 8'd3, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_target_memory.md
BUS_TARGET_MEMORY -- requirements
Module: bus_target_memory

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h5000_0000, byte address of the first word of the target window.
REQ-002 SHALL have parameter ADDR_BITS, default 8, log2 of window depth in 32-bit words (256 words).
REQ-003 SHALL have ports:
- clock  input  1  system clock, all logic rising-edge.
- n_reset  input  1  asynchronous, active-low reset.
- address_dataIN  input  32  address on the begin cycle, write data otherwise.
- byte_enableIN  input  4  byte lanes for writes; sampled on each valid write word.
- burst_sizeIN  input  8  burst length minus one; sampled on the begin cycle.
- read_n_writeIN  input  1  1=read, 0=write; sampled on the begin cycle.
- begin_transactionIN  input  1  one-cycle transaction start.
- end_transactionIN  input  1  initiator end or abort.
- data_validIN  input  1  write word present.
- busyIN  input  1  initiator cannot accept a read word this cycle.
- address_dataOUT  output  32  read data.
- end_transactionOUT  output  1  read burst complete.
- data_validOUT  output  1  read word present.
- busyOUT  output  1  target stall, constant 0.
- errorOUT  output  1  transaction rejected.

Function
REQ-004 SHALL hold 2^ADDR_BITS x 32-bit words, single-port synchronous RAM, contents uninitialised and never cleared by reset.
REQ-005 SHALL select itself when begin_transactionIN=1 in IDLE and address_dataIN[31:ADDR_BITS+2] equals BASE_ADDRESS[31:ADDR_BITS+2]; otherwise SHALL stay IDLE with all outputs 0.
REQ-006 SHALL, on a selected begin with address_dataIN[1:0]!=0, assert errorOUT for exactly one cycle on the next cycle and return to IDLE without touching RAM.
REQ-007 SHALL use states IDLE, WRITE, READ_FETCH, READ_DATA, READ_END, ERROR.
REQ-008 SHALL latch word index = address_dataIN[ADDR_BITS+1:2] and remaining count = burst_sizeIN+1 on an accepted begin.
REQ-009 SHALL increment word index modulo 2^ADDR_BITS after each transferred word (wrap within window, no error).
REQ-010 WRITE: each cycle with data_validIN=1 and count>0 SHALL write address_dataIN to RAM[index] with only byte lanes where byte_enableIN[i]=1, then decrement count.
REQ-011 WRITE: data_validIN with count=0 SHALL be ignored; end_transactionIN SHALL return to IDLE on the next cycle, whether or not count has reached 0.
REQ-012 READ_FETCH SHALL last one cycle; the first data_validOUT=1 SHALL appear two cycles after the begin cycle.
REQ-013 READ_DATA SHALL drive data_validOUT=1 with address_dataOUT=RAM[index]; while busyIN=1 the same word SHALL be held; the word is consumed on a cycle with busyIN=0.
REQ-014 Consecutive unstalled read words SHALL stream one per cycle, with no bubbles.
REQ-015 After the last word is consumed, READ_END SHALL assert end_transactionOUT=1 for exactly one cycle with data_validOUT=0, then return to IDLE.
REQ-016 end_transactionIN during READ_FETCH or READ_DATA SHALL abort to IDLE on the next cycle without end_transactionOUT.
REQ-017 byte_enableIN SHALL be ignored for reads; full words are returned.
REQ-018 begin_transactionIN outside IDLE SHALL be ignored.
REQ-019 address_dataOUT, data_validOUT, end_transactionOUT and errorOUT SHALL be 0 in every cycle in which they are not actively asserted, so they can be OR-combined on the shared bus.
REQ-020 busyOUT SHALL be constant 0.

Reset
REQ-021 n_reset=0 SHALL immediately force IDLE, count=0, index=0, and all outputs 0, including in the middle of a burst.
REQ-022 After n_reset rises, the first begin_transactionIN SHALL be accepted on the first clock edge.

Verification
REQ-023 Write burst: begin addr 0x5000_0010, size 3, write; 4 words 0xA0..0xA3 with byte_enable 0xF; end -> then read burst same addr, size 3 returns 0xA0,0xA1,0xA2,0xA3, first valid 2 cycles after begin, then end_transactionOUT one cycle.
REQ-024 Byte enables: word 0xFFFF_FFFF at 0x5000_0000, then write 0x1234_5678 with byte_enable 4'b0101 -> read returns 0xFF34_FF78.
REQ-025 Wrap: write size 1 at 0x5000_03FC with 0x11, 0x22 -> index 255 holds 0x11, index 0 (0x5000_0000) holds 0x22, errorOUT stays 0.
REQ-026 busyIN stall: read size 2 with busyIN=1 for 3 cycles on word 1 -> word 1 held 4 cycles, exactly 3 words delivered, then end_transactionOUT.
REQ-027 Rejections: begin at 0x6000_0000 -> no output activity; begin at 0x5000_0002 -> errorOUT=1 for one cycle, RAM unchanged.
REQ-028 Reset mid-read: n_reset=0 during READ_DATA -> outputs 0 asynchronously; after release, a read of previously written data returns the unchanged contents.
